sprite_palette_engine: RTL and testbench

Parametrised, writable, multi-bank sprite palette for the VGA pixel path. It sits between the sprite/background ROM index fetch and the colour mapper. It converts a pixel index into RGB through a two-stage pipeline and flags the transparent key entry. Software can rewrite entries at runtime, and the active bank switches only on frame boundaries. With fade support compiled in, it also applies a frame-stepped brightness fade.

---
 rtl/sprite_palette_engine.sv | 149 ++++++++++++++
 tb/tb_sprite_palette_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_engine.sv
// Multi-bank writable sprite palette: index -> RGB in two pipeline stages with
// frame-synchronous bank switching. Define PALETTE_FADE_EN to add the brightness fade.
module sprite_palette_engine #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int BANKS = 4,
    parameter logic [3*CH_W-1:0] KEY_RGB = 12'h6DF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(BANKS)-1:0] wr_bank,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [3*CH_W-1:0]        wr_rgb,
    input  logic                     bank_req,
    input  logic [$clog2(BANKS)-1:0] bank_req_sel,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [IDX_W-1:0]         pix_idx,
    input  logic                     fade_cmd,
    input  logic                     fade_dir,
    output logic                     out_valid,
    output logic [CH_W-1:0]          red,
    output logic [CH_W-1:0]          green,
    output logic [CH_W-1:0]          blue,
    output logic                     transparent,
    output logic [$clog2(BANKS)-1:0] active_bank,
    output logic                     fade_busy
);
    localparam int BW      = $clog2(BANKS);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int RGB_W   = 3 * CH_W;

    logic [RGB_W-1:0] pal [BANKS][ENTRIES];
    logic [BW-1:0]    pending;
    logic [RGB_W-1:0] s1_rgb;
    logic             s1_key;
    logic [2:1]       vld_pipe;
    logic [CH_W-1:0]  r_nxt, g_nxt, b_nxt;

    // Reads see the pre-write contents because the write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BANKS; b++)
                for (int e = 0; e < ENTRIES; e++)
                    pal[b][e] <= (e == 0) ? KEY_RGB : '1;
        end else if (wr_en) begin
            pal[wr_bank][wr_idx] <= wr_rgb;
        end
    end

    // A request arriving together with frame_start bypasses the pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            active_bank <= '0;
        end else begin
            if (bank_req)
                pending <= bank_req_sel;
            if (frame_start)
                active_bank <= bank_req ? bank_req_sel : pending;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rgb      <= '0;
            s1_key      <= 1'b0;
            vld_pipe    <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], pix_valid};
            if (pix_valid) begin
                s1_rgb <= pal[active_bank][pix_idx];
                s1_key <= (pix_idx == '0);
            end
            if (vld_pipe[1]) begin
                red         <= r_nxt;
                green       <= g_nxt;
                blue        <= b_nxt;
                transparent <= s1_key;
            end
        end
    end

    assign out_valid = vld_pipe[2];

`ifdef PALETTE_FADE_EN
    localparam logic [CH_W:0] FULL = {1'b1, {CH_W{1'b0}}};

    logic [CH_W:0] level, target, tgt_nxt;

    function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c,
                                                input logic [CH_W:0] lv);
        logic [2*CH_W:0] p;
        p = {{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, lv};
        return p[2*CH_W-1:CH_W];
    endfunction

    always_comb begin
        tgt_nxt = target;
        if (fade_cmd)
            tgt_nxt = fade_dir ? '0 : FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= FULL;
            target <= FULL;
        end else begin
            target <= tgt_nxt;
            if (frame_start) begin
                if (level < tgt_nxt)
                    level <= level + 1'b1;
                else if (level > tgt_nxt)
                    level <= level - 1'b1;
            end
        end
    end

    assign fade_busy = (level != target);

    // The key entry bypasses the fade so the transparency colour stays exact.
    always_comb begin
        r_nxt = s1_rgb[RGB_W-1 -: CH_W];
        g_nxt = s1_rgb[2*CH_W-1 -: CH_W];
        b_nxt = s1_rgb[CH_W-1:0];
        if (!s1_key) begin
            r_nxt = fade_ch(s1_rgb[RGB_W-1 -: CH_W], level);
            g_nxt = fade_ch(s1_rgb[2*CH_W-1 -: CH_W], level);
            b_nxt = fade_ch(s1_rgb[CH_W-1:0], level);
        end
    end
`else
    logic unused_fade;
    assign unused_fade = fade_cmd ^ fade_dir;
    assign fade_busy   = 1'b0;

    always_comb begin
        r_nxt = s1_rgb[RGB_W-1 -: CH_W];
        g_nxt = s1_rgb[2*CH_W-1 -: CH_W];
        b_nxt = s1_rgb[CH_W-1:0];
    end
`endif

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Directed self-checking bench for sprite_palette_engine (default parameters).
module tb_sprite_palette_engine;
`ifdef PALETTE_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_idx = '0;
    logic [11:0] wr_rgb = '0;
    logic        bank_req = 1'b0;
    logic [1:0]  bank_req_sel = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [3:0]  pix_idx = '0;
    logic        fade_cmd = 1'b0;
    logic        fade_dir = 1'b0;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic [1:0]  active_bank;
    logic        fade_busy;

    int n_cmp = 0;
    int n_err = 0;

    sprite_palette_engine dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
        .wr_rgb(wr_rgb), .bank_req(bank_req), .bank_req_sel(bank_req_sel),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_idx(pix_idx),
        .fade_cmd(fade_cmd), .fade_dir(fade_dir), .out_valid(out_valid),
        .red(red), .green(green), .blue(blue), .transparent(transparent),
        .active_bank(active_bank), .fade_busy(fade_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single pixel through the pipe: sampled at the first edge, visible after the second.
    task automatic read_px(input string tag, input logic [3:0] idx,
                           input logic [11:0] exp_rgb, input logic exp_tr);
        pix_valid = 1'b1;
        pix_idx   = idx;
        tick();
        pix_valid = 1'b0;
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_rgb"}, {20'd0, red, green, blue}, {20'd0, exp_rgb});
        check({tag, "_tr"}, {31'd0, transparent}, {31'd0, exp_tr});
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        check("rst_tr", {31'd0, transparent}, 32'd0);
        check("rst_bank", {30'd0, active_bank}, 32'd0);
        check("rst_busy", {31'd0, fade_busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Stream 0..15 back to back; output after tick i belongs to index i-1
        for (int i = 0; i < 18; i++) begin
            pix_valid = (i < 16);
            pix_idx   = 4'(i);
            tick();
            if (i >= 1 && i <= 16) begin
                check("strm_valid", {31'd0, out_valid}, 32'd1);
                check("strm_rgb", {20'd0, red, green, blue}, (i == 1) ? 32'h6DF : 32'hFFF);
                check("strm_tr", {31'd0, transparent}, (i == 1) ? 32'd1 : 32'd0);
            end else if (i == 17) begin
                check("strm_drop", {31'd0, out_valid}, 32'd0);
            end
        end
        pix_valid = 1'b0;

        // Write/read collision on bank0 idx5
        wr_en = 1'b1; wr_bank = 2'd0; wr_idx = 4'd5; wr_rgb = 12'h000;
        pix_valid = 1'b1; pix_idx = 4'd5;
        tick();
        wr_en = 1'b0;
        tick();
        check("coll_old", {20'd0, red, green, blue}, 32'hFFF);
        pix_valid = 1'b0;
        tick();
        check("coll_new", {20'd0, red, green, blue}, 32'h000);

        // Deferred bank switch
        wr_en = 1'b1; wr_bank = 2'd2; wr_idx = 4'd3; wr_rgb = 12'h123;
        tick();
        wr_en = 1'b0;
        bank_req = 1'b1; bank_req_sel = 2'd2;
        tick();
        bank_req = 1'b0;
        read_px("pend_px", 4'd3, 12'hFFF, 1'b0);
        check("pend_bank", {30'd0, active_bank}, 32'd0);
        // Pixel sampled on the frame_start edge still uses the old bank
        pix_valid = 1'b1; pix_idx = 4'd3; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("sw_bank", {30'd0, active_bank}, 32'd2);
        tick();
        check("sw_inflight", {20'd0, red, green, blue}, 32'hFFF);
        pix_valid = 1'b0;
        tick();
        check("sw_new", {20'd0, red, green, blue}, 32'h123);

        // Same-cycle request and frame_start
        bank_req = 1'b1; bank_req_sel = 2'd1; frame_start = 1'b1;
        tick();
        bank_req = 1'b0; frame_start = 1'b0;
        check("same_cyc", {30'd0, active_bank}, 32'd1);
        // Later request overwrites an earlier pending one
        bank_req = 1'b1; bank_req_sel = 2'd3;
        tick();
        bank_req_sel = 2'd2;
        tick();
        bank_req = 1'b0;
        frames(1);
        check("overwrite", {30'd0, active_bank}, 32'd2);

        // Fade out halfway, reverse, then full fade out
        fade_cmd = 1'b1; fade_dir = 1'b1;
        tick();
        fade_cmd = 1'b0;
        check("fade_busy0", {31'd0, fade_busy}, FADE ? 32'd1 : 32'd0);
        frames(8);
        read_px("fade_half", 4'd4, FADE ? 12'h777 : 12'hFFF, 1'b0);
        read_px("fade_key", 4'd0, 12'h6DF, 1'b1);
        check("fade_busy1", {31'd0, fade_busy}, FADE ? 32'd1 : 32'd0);
        fade_cmd = 1'b1; fade_dir = 1'b0;
        tick();
        fade_cmd = 1'b0;
        frames(8);
        read_px("fade_back", 4'd4, 12'hFFF, 1'b0);
        check("fade_busy2", {31'd0, fade_busy}, 32'd0);
        fade_cmd = 1'b1; fade_dir = 1'b1;
        tick();
        fade_cmd = 1'b0;
        frames(16);
        read_px("fade_black", 4'd4, FADE ? 12'h000 : 12'hFFF, 1'b0);
        check("fade_busy3", {31'd0, fade_busy}, 32'd0);

        // Mid-stream asynchronous reset with bank2 active
        pix_valid = 1'b1; pix_idx = 4'd3;
        tick();
        tick();
        check("mid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_bank", {30'd0, active_bank}, 32'd0);
        pix_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_busy", {31'd0, fade_busy}, 32'd0);
        read_px("mid_entry", 4'd5, 12'hFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
